// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter / return-address stack slice.
package pc_pkg;

    localparam int DEFAULT_ADDR_W    = 8;
    localparam int DEFAULT_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_BRANCH,
        SEL_INC,
        SEL_EXC
    } next_sel_t;

    // Smallest n with 2**n >= value; used to size the RAS pointer.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular LIFO of return addresses; a push while full silently overwrites the oldest entry.
module pc_ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign overflow = push & full;
    // ptr_q is the next free slot, so the top of stack sits one below it.
    assign top_data = mem_q[ptr_q - PTR_W'(1)];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with stall, branch, call/return and a hardware return-address stack.
// Define PC_RAS_EXC_EN to add the exception request input, EPC output and EXC_VEC parameter.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                RAS_DEPTH = DEFAULT_RAS_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
`ifdef PC_RAS_EXC_EN
    ,
    parameter logic [ADDR_W-1:0] EXC_VEC   = '1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
`ifdef PC_RAS_EXC_EN
    input  logic              exc_req,
    output logic [ADDR_W-1:0] epc,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_err_q, ras_err_d;
    logic              ras_overflow;
    logic              underflow;
    logic              push, pop;
    next_sel_t         sel;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign push   = (sel == SEL_CALL);
    assign pop    = (sel == SEL_RET);

    pc_ras_stack #(
        .ADDR_W(ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(pc_inc),
        .top_data (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .overflow (ras_overflow)
    );

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        sel       = SEL_INC;
        underflow = 1'b0;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            if (ras_empty) begin
                underflow = 1'b1;
            end else begin
                sel = SEL_RET;
            end
        end else if (call) begin
            sel = SEL_CALL;
        end else if (branch) begin
            sel = SEL_BRANCH;
        end
`ifdef PC_RAS_EXC_EN
        // Exceptions pre-empt stall and every control strobe.
        if (exc_req) begin
            sel       = SEL_EXC;
            underflow = 1'b0;
        end
`endif
    end

    always_comb begin
        pc_d      = pc_inc;
        ras_err_d = ras_err_q | underflow | ras_overflow;
        unique case (sel)
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = ras_top;
            SEL_CALL:   pc_d = target;
            SEL_BRANCH: pc_d = target;
`ifdef PC_RAS_EXC_EN
            SEL_EXC:    pc_d = EXC_VEC;
`endif
            default:    pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VEC;
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ras_err_q <= ras_err_d;
        end
    end

`ifdef PC_RAS_EXC_EN
    logic [ADDR_W-1:0] epc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (sel == SEL_EXC) begin
            epc_q <= pc_q;
        end
    end

    assign epc = epc_q;
`endif

    assign pc      = pc_q;
    assign ras_err = ras_err_q;

endmodule
